// File: rtl/ps2_scan_receiver_pkg.sv
// Shared definitions for the PS/2 scan-code receiver and its consumers:
// FSM state encoding, common scan-set-2 byte constants and the frame parity check.
package ps2_scan_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] ENTER     = 8'h5A;
  localparam logic [7:0] BACKSPACE = 8'h66;
  localparam logic [7:0] RELEASE   = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] byte_val, input logic par);
    return ^{byte_val, par};
  endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Byte-stream interface between the PS/2 receiver (master) and the key consumers (slave).
interface ps2_scan_receiver_if;
  logic [7:0] data;
  logic       data_en;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output data, output data_en, output parity_err, output frame_err, output busy);
  modport slave  (input  data, input  data_en, input  parity_err, input  frame_err, input  busy);
endinterface

// File: rtl/ps2_scan_receiver_clk_filter.sv
// PS/2 line front end: synchronisers on clock and data, a glitch filter on the clock,
// and a one-cycle pulse on each filtered falling edge with the synced data bit alongside.
module ps2_scan_receiver_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic Clock,
  input  logic nReset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [CW-1:0]          flt_cnt;
  logic                   filt;
  logic                   clk_s;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat   = dat_sync[SYNC_STAGES-1];

  // Preset high so that releasing reset on an idle bus never looks like an edge.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      flt_cnt <= '0;
      filt    <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
        filt    <= clk_s;
        flt_cnt <= '0;
        fall    <= filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver producing scan-code bytes with a one-cycle strobe.
// Optional inter-edge timeout enabled by defining PS2_RX_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0); a 1 is ignored
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_scan_receiver
  import ps2_scan_receiver_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  PS2_CLK,
  input  logic                  PS2_DAT,
  ps2_scan_receiver_if.master   rx
);

  rx_state_t  state, state_nx;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic       par_q, par_nx;
  logic [7:0] data_q, data_nx;
  logic       en_q, en_nx;
  logic       perr_q, perr_nx;
  logic       ferr_q, ferr_nx;
  logic       edge_ev;
  logic       bit_in;
  logic       timeout;

  ps2_scan_receiver_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .Clock   (Clock),
    .nReset  (nReset),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .fall    (edge_ev),
    .dat     (bit_in)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tmo_cnt <= '0;
    end else if (edge_ev || state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // An edge arriving at terminal count keeps the frame alive.
  assign timeout = (state != ST_IDLE) && !edge_ev && (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      par_q   <= par_nx;
      data_q  <= data_nx;
      en_q    <= en_nx;
      perr_q  <= perr_nx;
      ferr_q  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    par_nx     = par_q;
    data_nx    = data_q;
    en_nx      = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    if (timeout) begin
      state_nx = ST_IDLE;
      ferr_nx  = 1'b1;
    end else if (edge_ev) begin
      case (state)
        ST_IDLE: begin
          if (!bit_in) begin
            state_nx   = ST_DATA;
            bit_cnt_nx = '0;
          end
        end
        ST_DATA: begin
          shreg_nx   = {bit_in, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          par_nx   = bit_in;
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (!bit_in) begin
            ferr_nx = 1'b1;
          end else if (parity_ok(shreg, par_q)) begin
            data_nx = shreg;
            en_nx   = 1'b1;
          end else begin
            perr_nx = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign rx.data       = data_q;
  assign rx.data_en    = en_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: 1 MHz system clock, 80 us PS/2 bit period.
`timescale 1ns/1ps
module tb_ps2_scan_receiver;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  int n_vec  = 0;
  int n_err  = 0;
  int en_cnt = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int viol   = 0;
  int en0, pe0, fe0;
  logic [7:0] cap[$];
  logic prev_any = 1'b0;

  ps2_scan_receiver_if rx_if ();

  ps2_scan_receiver #(
    .CLK_FREQ_HZ (1_000_000),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .TIMEOUT_US  (2000)
  ) dut (
    .Clock   (clk),
    .nReset  (rst_n),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .rx      (rx_if)
  );

  always #500 clk = ~clk;

  // Strobe monitor: counts pulses, logs accepted bytes, flags overlaps and stretched strobes.
  always @(negedge clk) begin
    logic any;
    any = rx_if.data_en | rx_if.parity_err | rx_if.frame_err;
    if (rx_if.data_en) begin
      en_cnt++;
      cap.push_back(rx_if.data);
    end
    if (rx_if.parity_err) pe_cnt++;
    if (rx_if.frame_err) fe_cnt++;
    if ((int'(rx_if.data_en) + int'(rx_if.parity_err) + int'(rx_if.frame_err)) > 1) viol++;
    if (any && prev_any) viol++;
    prev_any = any;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    en0 = en_cnt;
    pe0 = pe_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(40);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(8);
    end else begin
      wait_cyc(20);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int glitch_idx);
    logic [10:0] frm;
    frm = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(frm[i], i == glitch_idx);
    ps2_dat = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    ps2_dat = 1'b1;
  endtask

  initial begin
    int idx;
    // reset values
    wait_cyc(5);
    check("rst_data", 32'(rx_if.data), 32'h00);
    check("rst_data_en", 32'(rx_if.data_en), 32'h0);
    check("rst_parity_err", 32'(rx_if.parity_err), 32'h0);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
    check("rst_busy", 32'(rx_if.busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);
    check("release_no_edge_busy", 32'(rx_if.busy), 32'h0);
    check("release_no_strobes", 32'(en_cnt + pe_cnt + fe_cnt), 32'd0);

    // 1: single 0x16
    snap();
    send_frame(8'h16, 1'b0, 1'b1, -1);
    check("t1_data", 32'(rx_if.data), 32'h16);
    check("t1_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("t1_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);
    check("t1_busy", 32'(rx_if.busy), 32'h0);

    // 2: back-to-back 0xF0, 0x16
    snap();
    idx = cap.size();
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h16, 1'b0, 1'b1, -1);
    check("t2_en_pulses", 32'(en_cnt - en0), 32'd2);
    check("t2_first", 32'(cap[idx]), 32'hF0);
    check("t2_second", 32'(cap[idx+1]), 32'h16);

    // 3: 0x5A with bad parity
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check("t3_parity_err", 32'(pe_cnt - pe0), 32'd1);
    check("t3_no_en", 32'(en_cnt - en0), 32'd0);
    check("t3_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("t3_data_held", 32'(rx_if.data), 32'h16);

    // 4: 0x45 with stop 0, then clean 0x45
    snap();
    send_frame(8'h45, 1'b0, 1'b0, -1);
    check("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t4_no_parity_err", 32'(pe_cnt - pe0), 32'd0);
    check("t4_no_en", 32'(en_cnt - en0), 32'd0);
    check("t4_data_held", 32'(rx_if.data), 32'h16);
    snap();
    send_frame(8'h45, 1'b0, 1'b1, -1);
    check("t4_clean_data", 32'(rx_if.data), 32'h45);
    check("t4_clean_en", 32'(en_cnt - en0), 32'd1);

    // 5: 2-cycle glitches idle and mid-frame
    snap();
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check("t5_idle_glitch_busy", 32'(rx_if.busy), 32'h0);
    send_frame(8'h26, 1'b0, 1'b1, 4);
    check("t5_data", 32'(rx_if.data), 32'h26);
    check("t5_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("t5_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);

    // 6: reset mid-frame, then a fresh 0x1E
    send_partial(8'h1E, 5);
    check("t6_busy_mid", 32'(rx_if.busy), 32'h1);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    check("t6_busy_after_rst", 32'(rx_if.busy), 32'h0);
    check("t6_data_after_rst", 32'(rx_if.data), 32'h00);
    snap();
    send_frame(8'h1E, 1'b1, 1'b1, -1);
    check("t6_data", 32'(rx_if.data), 32'h1E);
    check("t6_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("t6_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
    snap();
    send_partial(8'h1E, 3);
    wait_cyc(1900);
    check("tmo_not_yet", 32'(fe_cnt - fe0), 32'd0);
    check("tmo_busy_waiting", 32'(rx_if.busy), 32'h1);
    wait_cyc(600);
    check("tmo_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("tmo_busy_cleared", 32'(rx_if.busy), 32'h0);
    snap();
    send_frame(8'h1E, 1'b1, 1'b1, -1);
    check("tmo_next_data", 32'(rx_if.data), 32'h1E);
    check("tmo_next_en", 32'(en_cnt - en0), 32'd1);
`endif

    check("strobe_exclusive_1cycle", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
